core_mem_router: RTL and testbench
==================================

Name: core_mem_router

Overview:
- Sits directly upstream of the instruction memory, between the core's native memory port (valid/ready, addr, wdata, wstrb, rdata) and two slaves.
- Slave 1 is the instruction memory: 9-bit byte address, one-cycle-after-valid ready pulse.
- Slave 2 is the data/coherence bus port.
- Decodes each core request, forwards it to exactly one slave, and returns the response to the core.
- Completes unmapped, write-protected and timed-out accesses locally with an error indication, so the core never hangs.

Parameters:
- IMEM_BASE, 32'h0000_0000, byte base of the instruction memory window.
- IMEM_BYTES, 512, window size in bytes; equals the 9-bit imem address space.
- DMEM_BASE, 32'h0000_1000, byte base of the data window.
- DMEM_BYTES, 32'h0000_1000, data window size in bytes.
- IMEM_WRITABLE, 1, 0 = writes to the imem window are rejected and not forwarded.
- TIMEOUT_CYCLES, 255, maximum wait cycles for slave ready; must be ≥2.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- core_valid  in  1  core request valid
- core_ready  out  1  one-cycle completion pulse to core
- core_addr  in  32  byte address
- core_wdata  in  32  write data
- core_wstrb  in  4  byte write strobes; 0 = read
- core_rdata  out  32  read data, valid while core_ready=1
- imem_valid  out  1  request to instruction memory
- imem_ready  in  1  instruction memory completion
- imem_addr  out  9  offset within the imem window
- imem_wdata  out  32  write data
- imem_wstrb  out  4  strobes
- imem_rdata  in  32  read data
- dmem_valid  out  1  request to data port
- dmem_ready  in  1  data port completion
- dmem_addr  out  32  full byte address, passed unmodified
- dmem_wdata  out  32  write data
- dmem_wstrb  out  4  strobes
- dmem_rdata  in  32  read data
- err_valid  out  1  one-cycle pulse, coincident with core_ready, on an errored access
- err_cause  out  2  01 decode, 10 timeout, 11 write-protect; holds until the next error
- err_count  out  8  saturating count of errored accesses

Behaviour:
- Reset (resetn=0 at a clk edge):
  - all outputs become 0; state IDLE; timer 0; err_count 0.
  - Applies mid-transaction: any in-flight slave valid drops and the transaction is abandoned; no core_ready is issued.
- All outputs are registered.
- States: IDLE, IMEM_WAIT, DMEM_WAIT, RESP.
- IDLE, with core_valid=1 and core_ready=0:
  - latch addr, wdata and wstrb; decode on the latched values.
  - In imem window (IMEM_BASE ≤ addr < IMEM_BASE+IMEM_BYTES):
    - write with IMEM_WRITABLE=0: go to RESP, cause 11, rdata 0.
    - otherwise: imem_valid<=1, imem_addr<=addr-IMEM_BASE (low 9 bits), go to IMEM_WAIT.
  - In dmem window: dmem_valid<=1, go to DMEM_WAIT.
  - Otherwise: go to RESP, cause 01, rdata 0.
- The two windows must not overlap; an overlap is a configuration error, and the bench asserts it at elaboration.
- IMEM_WAIT / DMEM_WAIT:
  - Slave outputs are held stable; the timer increments each cycle.
  - On slave ready: capture slave rdata into core_rdata, drop slave valid, go to RESP.
  - On timer==TIMEOUT_CYCLES-1 without ready: drop slave valid, rdata 0, cause 10, go to RESP.
  - Ready and timeout in the same cycle: ready wins, no error.
  - A slave ready arriving after a timeout, while the router is in IDLE or RESP, is ignored.
- RESP:
  - core_ready=1 for exactly one cycle; err_valid=1 in the same cycle if errored.
  - err_count increments, saturating at 255.
  - Next state is IDLE; the timer clears.
- Slave valid always drops the cycle after the slave's ready is sampled. This satisfies the imem rule that valid must not remain high after a ready pulse, which would otherwise restart the access.
- core_rdata holds its last value outside RESP; write accesses return rdata 0.
- Latency, core_valid rising at cycle 0:
  - imem: core_ready at cycle 3.
  - dmem with slave ready at cycle k: core_ready at k+1.
  - decode and write-protect errors: core_ready at cycle 1.
- Core contract: core_valid drops within the cycle after core_ready. The router never accepts in the same cycle core_ready=1.
- One outstanding transaction at a time; no pipelining.

Decomposition:
- Package core_mem_router_pkg holds:
  - state enum (IDLE, IMEM_WAIT, DMEM_WAIT, RESP);
  - err_cause enum (NONE=00, DECODE=01, TIMEOUT=10, WPROT=11);
  - default window constants.
- One natural combinational sub-module, mem_addr_decode:
  - inputs: addr, wstrb, parameters;
  - outputs: hit_imem, hit_dmem, wprot_violation.
- FSM, timer and error counters stay in the top.

Test Plan:
1. imem holds word 0x00110113 at index 4; core reads addr 0x10 → imem_addr=0x010, core_ready at cycle 3, core_rdata=0x00110113, err_valid=0.
2. Core writes addr 0x08, wdata 0xAABBCCDD, wstrb 4'b0011; then reads 0x08 → only the low two bytes change, ending in 0xCCDD; imem_valid high for exactly 2 cycles per access.
3. dmem model with ready 5 cycles after valid; read 0x1004 → dmem_addr=0x1004, core_ready the cycle after dmem_ready, rdata = model value.
4. Core reads 0x0800 (unmapped) → core_ready at cycle 1, rdata 0, err_valid=1, err_cause=01, err_count=1; no slave valid asserted.
5. TIMEOUT_CYCLES=16, dmem never ready → dmem_valid high 16 cycles then drops, core_ready next cycle, err_cause=10. Second case: ready on cycle 16 → no error.
6. Assert resetn=0 while in DMEM_WAIT → next edge: dmem_valid=0, state IDLE, err_count=0, no core_ready. With IMEM_WRITABLE=0, a write to 0x0 → err_cause=11 and imem_valid never rises.

Source files
------------

// File: rtl/core_mem_router_pkg.sv
// core_mem_router_pkg: shared state/error encodings and default address windows
package core_mem_router_pkg;
    typedef enum logic [1:0] {IDLE, IMEM_WAIT, DMEM_WAIT, RESP} state_t;
    typedef enum logic [1:0] {NONE = 2'b00, DECODE = 2'b01, TIMEOUT = 2'b10, WPROT = 2'b11} err_cause_t;
    localparam logic [31:0] DEF_IMEM_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_IMEM_BYTES = 32'd512;
    localparam logic [31:0] DEF_DMEM_BASE = 32'h0000_1000;
    localparam logic [31:0] DEF_DMEM_BYTES = 32'h0000_1000;
    localparam bit DEF_IMEM_WRITABLE = 1'b1;
    localparam int DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/mem_addr_decode.sv
// mem_addr_decode: window hit and write-protect decode for a core request
module mem_addr_decode
    import core_mem_router_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE = DEF_IMEM_BASE,
    parameter logic [31:0] IMEM_BYTES = DEF_IMEM_BYTES,
    parameter logic [31:0] DMEM_BASE = DEF_DMEM_BASE,
    parameter logic [31:0] DMEM_BYTES = DEF_DMEM_BYTES,
    parameter bit IMEM_WRITABLE = DEF_IMEM_WRITABLE
) (
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    output logic        hit_imem,
    output logic        hit_dmem,
    output logic        wprot_violation
);
    // Unsigned wrap makes addresses below the base land far outside the window
    assign hit_imem = (addr - IMEM_BASE) < IMEM_BYTES;
    assign hit_dmem = (addr - DMEM_BASE) < DMEM_BYTES;
    assign wprot_violation = hit_imem && |wstrb && !IMEM_WRITABLE;
endmodule

// File: rtl/core_mem_router.sv
// core_mem_router: routes core requests to imem or dmem, completing errors and timeouts locally
module core_mem_router
    import core_mem_router_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE = DEF_IMEM_BASE,
    parameter logic [31:0] IMEM_BYTES = DEF_IMEM_BYTES,
    parameter logic [31:0] DMEM_BASE = DEF_DMEM_BASE,
    parameter logic [31:0] DMEM_BYTES = DEF_DMEM_BYTES,
    parameter bit IMEM_WRITABLE = DEF_IMEM_WRITABLE,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        core_valid,
    output logic        core_ready,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_wstrb,
    output logic [31:0] core_rdata,
    output logic        imem_valid,
    input  logic        imem_ready,
    output logic [8:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic [3:0]  imem_wstrb,
    input  logic [31:0] imem_rdata,
    output logic        dmem_valid,
    input  logic        dmem_ready,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_rdata,
    output logic        err_valid,
    output logic [1:0]  err_cause,
    output logic [7:0]  err_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    state_t state, state_next;
    err_cause_t cause_next;
    logic [TW-1:0] timer;
    logic wr, hit_imem, hit_dmem, wprot, accept, waiting, slave_ready, expired, to_resp;
    logic [31:0] slave_rdata;

    mem_addr_decode #(
        .IMEM_BASE(IMEM_BASE), .IMEM_BYTES(IMEM_BYTES), .DMEM_BASE(DMEM_BASE),
        .DMEM_BYTES(DMEM_BYTES), .IMEM_WRITABLE(IMEM_WRITABLE)
    ) u_decode (
        .addr(core_addr), .wstrb(core_wstrb), .hit_imem(hit_imem),
        .hit_dmem(hit_dmem), .wprot_violation(wprot)
    );

    always_ff @(posedge clk) state <= !resetn ? IDLE : state_next;

    always_comb begin
        state_next = state;
        cause_next = NONE;
        accept = state == IDLE && core_valid && !core_ready;
        waiting = state == IMEM_WAIT || state == DMEM_WAIT;
        slave_ready = state == IMEM_WAIT ? imem_ready : dmem_ready;
        slave_rdata = state == IMEM_WAIT ? imem_rdata : dmem_rdata;
        expired = timer == TW'(TIMEOUT_CYCLES - 1);
        if (accept) begin
            cause_next = wprot ? WPROT : (!hit_imem && !hit_dmem) ? DECODE : NONE;
            state_next = cause_next != NONE ? RESP : hit_imem ? IMEM_WAIT : DMEM_WAIT;
        end else if (waiting && (slave_ready || expired)) begin
            cause_next = slave_ready ? NONE : TIMEOUT;
            state_next = RESP;
        end else if (state == RESP) begin
            state_next = IDLE;
        end
        to_resp = state != RESP && state_next == RESP;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            core_ready <= 1'b0;
            core_rdata <= '0;
            imem_valid <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            imem_wstrb <= '0;
            dmem_valid <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= '0;
            err_valid  <= 1'b0;
            err_cause  <= NONE;
            err_count  <= '0;
            timer      <= '0;
            wr         <= 1'b0;
        end else begin
            core_ready <= to_resp;
            err_valid <= to_resp && cause_next != NONE;
            timer <= waiting && !to_resp ? timer + 1'b1 : '0;
            if (accept) wr <= |core_wstrb;
            if (to_resp && cause_next != NONE) begin
                err_cause <= cause_next;
                err_count <= err_count + {7'd0, err_count != 8'hFF};
            end
            // Reads that completed cleanly return slave data; writes and errors return zero
            if (to_resp) core_rdata <= waiting && cause_next == NONE && !wr ? slave_rdata : '0;
            if (accept && state_next == IMEM_WAIT) begin
                imem_valid <= 1'b1;
                imem_addr  <= 9'(core_addr - IMEM_BASE);
                imem_wdata <= core_wdata;
                imem_wstrb <= core_wstrb;
            end else if (state == IMEM_WAIT && to_resp) begin
                imem_valid <= 1'b0;
            end
            if (accept && state_next == DMEM_WAIT) begin
                dmem_valid <= 1'b1;
                dmem_addr  <= core_addr;
                dmem_wdata <= core_wdata;
                dmem_wstrb <= core_wstrb;
            end else if (state == DMEM_WAIT && to_resp) begin
                dmem_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_core_mem_router.sv
// tb_core_mem_router: directed and random transactions checked against a transaction-level model
module tb_core_mem_router;
    localparam logic [31:0] IB = 32'h0, IBY = 32'd512, DB = 32'h1000, DBY = 32'h1000;
    localparam int T = 16;

    logic clk, resetn, core_valid, core_valid_b;
    logic [31:0] core_addr, core_wdata;
    logic [3:0] core_wstrb;
    logic core_ready, imem_valid, imem_ready, dmem_valid, dmem_ready, err_valid;
    logic [31:0] core_rdata, imem_wdata, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic [8:0] imem_addr;
    logic [3:0] imem_wstrb, dmem_wstrb;
    logic [1:0] err_cause;
    logic [7:0] err_count;
    logic core_ready_b, imem_valid_b, dmem_valid_b, err_valid_b;
    logic [31:0] core_rdata_b, imem_wdata_b, dmem_addr_b, dmem_wdata_b;
    logic [8:0] imem_addr_b;
    logic [3:0] imem_wstrb_b, dmem_wstrb_b;
    logic [1:0] err_cause_b;
    logic [7:0] err_count_b;

    int tests = 0, fails = 0, d_delay = 1, dcnt, ref_errs;
    logic [1:0] ref_cause;
    logic [31:0] imem_arr [128];
    logic [31:0] ref_mem [128];

    core_mem_router #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .resetn(resetn), .core_valid(core_valid), .core_ready(core_ready),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_wstrb(core_wstrb), .core_rdata(core_rdata),
        .imem_valid(imem_valid), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata), .dmem_valid(dmem_valid), .dmem_ready(dmem_ready),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
        .err_valid(err_valid), .err_cause(err_cause), .err_count(err_count)
    );

    core_mem_router #(.IMEM_WRITABLE(1'b0)) dut_ro (
        .clk(clk), .resetn(resetn), .core_valid(core_valid_b), .core_ready(core_ready_b),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_wstrb(core_wstrb), .core_rdata(core_rdata_b),
        .imem_valid(imem_valid_b), .imem_ready(1'b0), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
        .imem_wstrb(imem_wstrb_b), .imem_rdata(32'h0), .dmem_valid(dmem_valid_b), .dmem_ready(1'b0),
        .dmem_addr(dmem_addr_b), .dmem_wdata(dmem_wdata_b), .dmem_wstrb(dmem_wstrb_b), .dmem_rdata(32'h0),
        .err_valid(err_valid_b), .err_cause(err_cause_b), .err_count(err_count_b)
    );

    initial if (IB < DB + DBY && DB < IB + IBY) $fatal(1, "imem and dmem windows overlap");

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return i == 4 ? 32'h0011_0113 : 32'hC0DE_0000 | (32'(i) * 32'h11);
    endfunction

    // imem slave: one-cycle ready pulse per access, byte-strobed writes, reloads during reset
    always @(posedge clk) begin
        if (!resetn) begin
            imem_ready <= 1'b0;
            for (int i = 0; i < 128; i++) imem_arr[i] <= init_word(i);
        end else if (imem_valid && !imem_ready) begin
            imem_ready <= 1'b1;
            if (imem_wstrb == 4'h0) imem_rdata <= imem_arr[imem_addr[8:2]];
            for (int i = 0; i < 4; i++)
                if (imem_wstrb[i]) imem_arr[imem_addr[8:2]][8*i +: 8] <= imem_wdata[8*i +: 8];
        end else begin
            imem_ready <= 1'b0;
        end
    end

    // dmem slave: ready arrives d_delay cycles after valid rises
    always @(posedge clk) begin
        if (!resetn || !dmem_valid || dmem_ready) begin
            dcnt <= 0;
            dmem_ready <= 1'b0;
        end else begin
            dcnt <= dcnt + 1;
            dmem_ready <= (dcnt + 1 == d_delay);
        end
    end
    assign dmem_rdata = dmem_addr ^ 32'h5A5A_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        ref_errs = 0;
        ref_cause = 2'b00;
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input int d);
        logic hit_i, hit_d, wr, ok;
        int lat, ivn, dvn, cyc, iv_cnt, dv_cnt;
        logic [1:0] cause;
        logic [31:0] rd, da;
        logic [8:0] ia;
        hit_i = a - IB < IBY;
        hit_d = a - DB < DBY;
        wr = ws != 4'h0;
        ok = d + 1 <= T;
        cause = 2'b00; rd = '0; ivn = 0; dvn = 0; lat = 1;
        if (hit_i) begin
            lat = 3; ivn = 2;
            if (!wr) rd = ref_mem[a[8:2]];
            for (int i = 0; i < 4; i++) if (ws[i]) ref_mem[a[8:2]][8*i +: 8] = wd[8*i +: 8];
        end else if (hit_d) begin
            lat = ok ? d + 2 : T + 1;
            dvn = ok ? d + 1 : T;
            cause = ok ? 2'b00 : 2'b10;
            if (ok && !wr) rd = a ^ 32'h5A5A_0000;
        end else begin
            cause = 2'b01;
        end
        if (cause != 2'b00) begin
            ref_cause = cause;
            if (ref_errs < 255) ref_errs++;
        end
        d_delay = d; core_addr = a; core_wdata = wd; core_wstrb = ws; core_valid = 1'b1;
        @(posedge clk); #1;
        cyc = 1; iv_cnt = 0; dv_cnt = 0; ia = '0; da = '0;
        while (!core_ready && cyc < 60) begin
            if (imem_valid) begin iv_cnt++; ia = imem_addr; end
            if (dmem_valid) begin dv_cnt++; da = dmem_addr; end
            @(posedge clk); #1;
            cyc++;
        end
        core_valid = 1'b0;
        chk("latency", cyc, lat);
        chk("core_rdata", core_rdata, rd);
        chk("err_valid", {31'd0, err_valid}, {31'd0, cause != 2'b00});
        chk("err_cause", {30'd0, err_cause}, {30'd0, ref_cause});
        chk("err_count", {24'd0, err_count}, ref_errs);
        chk("imem_valid_cycles", iv_cnt, ivn);
        chk("dmem_valid_cycles", dv_cnt, dvn);
        if (hit_i) chk("imem_addr", {23'd0, ia}, {23'd0, a[8:0]});
        if (hit_d) chk("dmem_addr", da, a);
        @(posedge clk); #1;
        chk("ready_pulse", {31'd0, core_ready}, 32'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] a;
        logic [3:0] ws;
        resetn = 1'b0; core_valid = 1'b0; core_valid_b = 1'b0;
        core_addr = '0; core_wdata = '0; core_wstrb = '0;
        ref_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {core_ready, imem_valid, dmem_valid, err_valid, err_cause, err_count}, 32'd0);
        chk("reset_rdata", core_rdata, 32'd0);
        chk("reset_imem_addr", {23'd0, imem_addr}, 32'd0);
        resetn = 1'b1;
        txn(32'h10, 32'h0, 4'h0, 1);
        txn(32'h08, 32'hAABB_CCDD, 4'b0011, 1);
        txn(32'h08, 32'h0, 4'h0, 1);
        txn(32'h1004, 32'h0, 4'h0, 5);
        txn(32'h0800, 32'h0, 4'h0, 1);
        txn(32'h1008, 32'h0, 4'h0, 200);
        txn(32'h100C, 32'h0, 4'h0, 15);
        txn(32'h1FFC, 32'h1234_5678, 4'hF, 3);
        txn(32'h2000, 32'h0, 4'h0, 1);
        txn(32'h1FC, 32'h0, 4'h0, 1);
        txn(32'h200, 32'h0, 4'h0, 1);
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: a = {21'd0, 7'($urandom_range(0, 127)), 2'b00};
                1: a = 32'h1000 + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
                default: a = $urandom | 32'h0001_0000;
            endcase
            ws = $urandom_range(0, 1) == 0 ? 4'h0 : 4'($urandom_range(1, 15));
            txn(a, $urandom, ws, $urandom_range(1, 20));
        end
        for (int n = 0; n < 258; n++) txn(32'h0002_0000 + 32'(n) * 4, 32'h0, 4'h0, 1);
        chk("err_count_saturated", {24'd0, err_count}, 32'd255);
        core_addr = 32'h1010; core_wstrb = 4'h0; d_delay = 200; core_valid = 1'b1;
        @(posedge clk); #1;
        core_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("dmem_valid_inflight", {31'd0, dmem_valid}, 32'd1);
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("reset_mid_dmem_valid", {31'd0, dmem_valid}, 32'd0);
        chk("reset_mid_core_ready", {31'd0, core_ready}, 32'd0);
        chk("reset_mid_err_count", {24'd0, err_count}, 32'd0);
        resetn = 1'b1;
        ref_reset();
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (core_ready || dmem_valid) seen++;
        end
        chk("no_activity_after_reset", seen, 0);
        txn(32'h10, 32'h0, 4'h0, 1);
        txn(32'h1020, 32'h0, 4'h0, 2);
        core_addr = 32'h0; core_wdata = 32'hDEAD_BEEF; core_wstrb = 4'hF; core_valid_b = 1'b1;
        seen = 0;
        @(posedge clk); #1;
        core_valid_b = 1'b0;
        chk("wprot_ready", {31'd0, core_ready_b}, 32'd1);
        chk("wprot_err_valid", {31'd0, err_valid_b}, 32'd1);
        chk("wprot_cause", {30'd0, err_cause_b}, 32'd3);
        chk("wprot_count", {24'd0, err_count_b}, 32'd1);
        chk("wprot_rdata", core_rdata_b, 32'd0);
        repeat (4) begin
            if (imem_valid_b) seen++;
            @(posedge clk); #1;
        end
        chk("wprot_imem_never_valid", seen, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
